md_iter_core: RTL and testbench

- Iterative radix-2 multiply/divide datapath that sits directly downstream of the execute-stage HI/LO control unit.
- The HI/LO unit issues an operation with a single-cycle start pulse. This core computes a 2*WIDTH-bit result over WIDTH+1 clock edges and returns it with a one-cycle done pulse.
- It replaces the behavioural "*", "/" and "%" operators with synthesizable shift-add multiply and restoring divide.
- busy feeds the stall logic. flush lets an interrupt or exception abort an operation in flight.

---
 rtl/md_iter_core_if.sv | 25 ++
 rtl/md_iter_core.sv | 168 ++++++++++++++++
 tb/tb_md_iter_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/md_iter_core_if.sv
// Handshake between the execute-stage HI/LO control unit (master) and the
// iterative multiply/divide core (slave).
interface md_iter_core_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/md_iter_core.sv
// Iterative radix-2 multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a final sign-correction cycle.
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   md_iter_core_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_q_q, neg_q_d;    // negate product / quotient
   logic             neg_r_q, neg_r_d;    // negate remainder
   logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
   logic [WIDTH:0]   rem_q, rem_d;        // upper accumulator / partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;        // multiplier bits / dividend bits -> quotient
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, mul_add;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_ok;
   logic [2*WIDTH-1:0] product, product_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand magnitudes; |most-negative| still fits as an unsigned WIDTH-bit value.
   always_comb begin
      signed_op = ~bus.op[0];
      a_neg     = signed_op & bus.src_a[WIDTH-1];
      b_neg     = signed_op & bus.src_b[WIDTH-1];
      mag_a     = a_neg ? -bus.src_a : bus.src_a;
      mag_b     = b_neg ? -bus.src_b : bus.src_b;
   end

   // One iteration of each algorithm plus the sign-corrected results.
   always_comb begin
      mul_sum     = {1'b0, rem_q[WIDTH-1:0]} + {1'b0, mcand_q};
      mul_add     = quo_q[0] ? mul_sum : {1'b0, rem_q[WIDTH-1:0]};
      div_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      div_diff    = {1'b0, div_shift} - {2'b00, mcand_q};
      div_ok      = ~div_diff[WIDTH+1];
      product     = {rem_q[WIDTH-1:0], quo_q};
      product_fix = neg_q_q ? -product : product;
      quo_fix     = neg_q_q ? -quo_q : quo_q;
      rem_fix     = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      mcand_d  = mcand_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (bus.flush) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d  = CALC;
                  cnt_d    = CW'(WIDTH);
                  busy_d   = 1'b1;
                  is_div_d = bus.op[1];
                  neg_q_d  = a_neg ^ b_neg;
                  neg_r_d  = a_neg;
                  rem_d    = '0;
                  if (bus.op[1]) begin
                     mcand_d = mag_b;
                     quo_d   = mag_a;
                  end else begin
                     mcand_d = mag_a;
                     quo_d   = mag_b;
                  end
               end
            end
            CALC: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FIX;
               if (is_div_q) begin
                  rem_d = div_ok ? div_diff[WIDTH:0] : div_shift;
                  quo_d = {quo_q[WIDTH-2:0], div_ok};
               end else begin
                  rem_d = {1'b0, mul_add[WIDTH:1]};
                  quo_d = {mul_add[0], quo_q[WIDTH-1:1]};
               end
            end
            FIX: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = product_fix[2*WIDTH-1:WIDTH];
                  lo_d = product_fix[WIDTH-1:0];
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         mcand_q  <= mcand_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_iter_core.sv
// Directed bench for md_iter_core: hand-computed products, quotients and
// remainders, latency, back-to-back, flush, ignored start and mid-op reset.
module tb_md_iter_core;

   localparam int W = 32;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   md_iter_core_if #(.WIDTH(W)) bus ();

   md_iter_core #(.WIDTH(W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Returns edges from the accepting edge to the done cycle and busy cycles seen.
   task automatic wait_done(input string tag, output int edges, output int busy_n);
      edges  = 0;
      busy_n = 0;
      while (bus.done !== 1'b1 && edges < 100) begin
         if (bus.busy === 1'b1) busy_n++;
         tick();
         edges++;
      end
      check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges, busy_n, done_n, busy_seen;

      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.flush = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_hi",   64'(bus.hi),   64'd0);
      check("rst_lo",   64'(bus.lo),   64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);

      // multu max * max, with latency and busy window
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", edges, busy_n);
      check("multu_max_latency", 64'(edges),  64'd33);
      check("multu_max_busy_n",  64'(busy_n), 64'd33);
      check("multu_max_busy_at_done", 64'(bus.busy), 64'd0);
      check("multu_max_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      check("multu_max_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      tick();
      check("done_single_pulse", 64'(bus.done), 64'd0);
      check("hold_hi_after_done", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);

      // mult -3 * 5, then div -7 / 2 issued in the done cycle
      start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done("mult_neg", edges, busy_n);
      check("mult_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      check("mult_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      check("b2b_busy", 64'(bus.busy), 64'd1);
      wait_done("b2b_div", edges, busy_n);
      check("b2b_latency", 64'(edges), 64'd33);
      check("div_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
      check("div_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);

      // divide by zero and signed overflow
      start_op(2'b11, 32'h0000_1234, 32'd0);
      wait_done("divu_zero", edges, busy_n);
      check("divu_zero_hi", 64'(bus.hi), 64'h0000_0000_0000_1234);
      check("divu_zero_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
      start_op(2'b10, 32'hFFFF_FFF9, 32'd0);
      wait_done("div_zero_neg", edges, busy_n);
      check("div_zero_neg_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      check("div_zero_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFF9);
      start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", edges, busy_n);
      check("div_ovf_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
      check("div_ovf_hi", 64'(bus.hi), 64'd0);

      // prior result hi=1, lo=2 from divu 5 / 2
      start_op(2'b11, 32'd5, 32'd2);
      wait_done("divu_5_2", edges, busy_n);
      check("divu_5_2_hi", 64'(bus.hi), 64'd1);
      check("divu_5_2_lo", 64'(bus.lo), 64'd2);

      // flush on the 10th CALC cycle, with a coincident start
      start_op(2'b01, 32'd7, 32'd9);
      for (int i = 0; i < 9; i++) tick();
      check("flush_pre_busy", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.src_a = 32'd77;
      bus.src_b = 32'd3;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      check("flush_busy", 64'(bus.busy), 64'd0);
      check("flush_done", 64'(bus.done), 64'd0);
      done_n    = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) done_n++;
         if (bus.busy === 1'b1) busy_seen++;
         tick();
      end
      check("flush_no_done",  64'(done_n),    64'd0);
      check("flush_no_busy",  64'(busy_seen), 64'd0);
      check("flush_hold_hi",  64'(bus.hi),    64'd1);
      check("flush_hold_lo",  64'(bus.lo),    64'd2);

      // start and operand changes during CALC are ignored
      start_op(2'b00, 32'hFFFF_FC18, 32'd3000);
      for (int i = 0; i < 4; i++) tick();
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.src_a = 32'd5;
      bus.src_b = 32'd6;
      tick();
      bus.start = 1'b0;
      bus.src_a = 32'hFFFF_FFFF;
      bus.src_b = 32'd0;
      tick();
      tick();
      bus.src_a = 32'h1234_5678;
      bus.op    = 2'b11;
      wait_done("ignore_start", edges, busy_n);
      check("ignore_start_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      check("ignore_start_lo", 64'(bus.lo), 64'h0000_0000_FFD2_3940);

      // reset mid-divide, then a clean divu 100 / 7
      start_op(2'b11, 32'd100, 32'd7);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_hi",   64'(bus.hi),   64'd0);
      check("midrst_lo",   64'(bus.lo),   64'd0);
      start_op(2'b11, 32'd100, 32'd7);
      wait_done("divu_100_7", edges, busy_n);
      check("divu_100_7_lo", 64'(bus.lo), 64'd14);
      check("divu_100_7_hi", 64'(bus.hi), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
